// File: rtl/dco_lock_monitor.sv
// Counts synchronized DCO rising edges per fixed window of system clocks and
// tracks lock status with separate acquire/release hysteresis counts.
module dco_lock_monitor #(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned EDGES_MIN     = 240,
    parameter int unsigned EDGES_MAX     = 272,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned UNLOCK_COUNT  = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             dco_in,
    input  logic             enable,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_valid,
    output logic             in_range,
    output logic             locked,
    output logic             lost,
    output logic [1:0]       state
);

    localparam int unsigned WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    logic             s1, s2, s3;
    logic             edge_det;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] total;
    logic             win_end;
    logic             win_in_range;

    state_t            state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic              lost_d;

    // Two-flop synchronizer plus history flop for rising-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= dco_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det     = s2 & ~s3;
    assign win_end      = enable && (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
    assign total        = (acc == '1) ? acc : acc + CNT_W'(edge_det);
    assign win_in_range = (total >= CNT_W'(EDGES_MIN)) && (total <= CNT_W'(EDGES_MAX));

    // Window timer and saturating edge accumulator; the closing cycle's edge is included
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_cnt     <= '0;
            acc         <= '0;
            edge_count  <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
        end else begin
            count_valid <= win_end;
            if (!enable) begin
                win_cnt <= '0;
                acc     <= '0;
            end else if (win_end) begin
                win_cnt    <= '0;
                acc        <= '0;
                edge_count <= total;
                in_range   <= win_in_range;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                acc     <= total;
            end
        end
    end

    // Lock FSM: decisions are taken on the window-closing cycle
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        lost_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            good_d  = '0;
            bad_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    bad_d = '0;
                    if (win_end) begin
                        if (!win_in_range) begin
                            good_d = '0;
                        end else if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    good_d = '0;
                    if (win_end) begin
                        if (win_in_range) begin
                            bad_d = '0;
                        end else if (bad_q == BAD_W'(UNLOCK_COUNT - 1)) begin
                            state_d = ACQUIRE;
                            bad_d   = '0;
                            lost_d  = 1'b1;
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            good_q  <= '0;
            bad_q   <= '0;
            locked  <= 1'b0;
            lost    <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            locked  <= (state_d == LOCKED);
            lost    <= lost_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_dco_lock_monitor.sv
// Window-scripted DCO stimulus checked against a window-history lock model.
module tb_dco_lock_monitor;

    localparam int WIN    = 1024;
    localparam int EMIN   = 240;
    localparam int EMAX   = 272;
    localparam int LOCK   = 4;
    localparam int UNLOCK = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        dco_in = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] edge_count;
    logic        count_valid;
    logic        in_range;
    logic        locked;
    logic        lost;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Reference model: per-window in-range history since the last lock transition
    bit   m_locked = 1'b0;
    bit   hist[$];
    int   m_edge = 0;
    bit   m_inr = 1'b0;
    logic prev_d = 1'b0;

    dco_lock_monitor dut (
        .clk        (clk),
        .rstn       (rstn),
        .dco_in     (dco_in),
        .enable     (enable),
        .edge_count (edge_count),
        .count_valid(count_valid),
        .in_range   (in_range),
        .locked     (locked),
        .lost       (lost),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic step(input logic d);
        dco_in = d;
        @(posedge clk);
        #1;
    endtask

    function automatic bit last_all(input int k, input bit v);
        for (int i = 0; i < k; i++)
            if (hist[hist.size() - 1 - i] != v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_window(input bit inr);
        bit lost_e = 1'b0;
        hist.push_back(inr);
        if (!m_locked) begin
            if (hist.size() >= LOCK && last_all(LOCK, 1'b1)) begin
                m_locked = 1'b1;
                hist.delete();
            end
        end else if (hist.size() >= UNLOCK && last_all(UNLOCK, 1'b0)) begin
            m_locked = 1'b0;
            lost_e   = 1'b1;
            hist.delete();
        end
        return lost_e;
    endfunction

    function automatic void model_idle();
        m_locked = 1'b0;
        hist.delete();
    endfunction

    // Drive one window (or its first len cycles); nominal selects a free-running clk/4 DCO
    task automatic run_window(input int n, input int start, input bit nominal, input int len);
        int         rises = 0;
        bit         bad_mid = 1'b0;
        bit         exp_inr;
        bit         exp_lost;
        logic       d;
        logic [1:0] st_exp;
        st_exp = m_locked ? 2'b10 : 2'b01;
        enable = 1'b1;
        for (int j = 0; j < len; j++) begin
            if (nominal) d = ((j % 4) < 2);
            else d = (j >= start) && (((j - start) % 3) == 0) && (((j - start) / 3) < n);
            if (d && !prev_d) rises++;
            prev_d = d;
            step(d);
            if (j < WIN - 1 && (count_valid !== 1'b0 || lost !== 1'b0 ||
                                state !== st_exp || locked !== m_locked))
                bad_mid = 1'b1;
        end
        checks++;
        if (bad_mid) begin
            errors++;
            $display("FAIL mid_window: pulse or status change inside window, got a change required none (n=%0d)", n);
        end
        if (len == WIN) begin
            exp_inr  = (rises >= EMIN) && (rises <= EMAX);
            exp_lost = model_window(exp_inr);
            m_edge   = rises;
            m_inr    = exp_inr;
            st_exp   = m_locked ? 2'b10 : 2'b01;
            checks++;
            if (count_valid !== 1'b1) begin
                errors++;
                $display("FAIL count_valid: got %b expected 1", count_valid);
            end
            checks++;
            if (edge_count !== 16'(rises)) begin
                errors++;
                $display("FAIL edge_count: got %0d expected %0d", edge_count, rises);
            end
            checks++;
            if (in_range !== exp_inr) begin
                errors++;
                $display("FAIL in_range: got %b expected %b (edges %0d)", in_range, exp_inr, rises);
            end
            checks++;
            if (locked !== m_locked) begin
                errors++;
                $display("FAIL locked: got %b expected %b", locked, m_locked);
            end
            checks++;
            if (lost !== exp_lost) begin
                errors++;
                $display("FAIL lost: got %b expected %b", lost, exp_lost);
            end
            checks++;
            if (state !== st_exp) begin
                errors++;
                $display("FAIL state: got %b expected %b", state, st_exp);
            end
        end
    endtask

    task automatic lock_up();
        for (int i = 0; i < 8 && !m_locked; i++) run_window(256, 16, 1'b0, WIN);
    endtask

    task automatic test_reset();
        bit seen = 1'b0;
        rstn   = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step(logic'(i % 2));
        checks++;
        if ({edge_count, count_valid, in_range, locked, lost, state} !== 22'h0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0",
                     {edge_count, count_valid, in_range, locked, lost, state});
        end
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (count_valid !== 1'b0 || state !== 2'b00) seen = 1'b1;
        end
        prev_d = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL idle_after_reset: got activity with enable low, expected state 00 and no count_valid");
        end
    endtask

    task automatic test_nominal_lock();
        for (int i = 0; i < LOCK; i++) run_window(0, 0, 1'b1, WIN);
        checks++;
        if (locked !== 1'b1 || state !== 2'b10) begin
            errors++;
            $display("FAIL lock_after_4: got locked=%b state=%b expected 1/10", locked, state);
        end
    endtask

    task automatic test_clock_loss();
        run_window(0, 16, 1'b0, WIN);
        run_window(0, 16, 1'b0, WIN);
        checks++;
        if (state !== 2'b01 || locked !== 1'b0) begin
            errors++;
            $display("FAIL loss_state: got state=%b locked=%b expected 01/0", state, locked);
        end
    endtask

    task automatic test_hysteresis();
        lock_up();
        run_window(128, 16, 1'b0, WIN);
        run_window(256, 16, 1'b0, WIN);
        run_window(0, 16, 1'b0, WIN);
        run_window(0, 16, 1'b0, WIN);
        for (int i = 0; i < 3; i++) run_window(256, 16, 1'b0, WIN);
        run_window(100, 16, 1'b0, WIN);
        for (int i = 0; i < 4; i++) run_window(256, 16, 1'b0, WIN);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL relock: got locked=%b expected 1", locked);
        end
    endtask

    task automatic test_bounds();
        int  n_arr[4]   = '{239, 240, 272, 273};
        bit  exp_arr[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_window(n_arr[i], 16, 1'b0, WIN);
            checks++;
            if (in_range !== exp_arr[i]) begin
                errors++;
                $display("FAIL bound_%0d: got in_range=%b expected %b", n_arr[i], in_range, exp_arr[i]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 12; i++) begin
            n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(230, 282));
            run_window(n, int'($urandom_range(4, 40)), 1'b0, WIN);
        end
    endtask

    task automatic test_enable_drop();
        lock_up();
        run_window(256, 16, 1'b0, 500);
        enable = 1'b0;
        step(1'b0);
        prev_d = 1'b0;
        model_idle();
        checks++;
        if (state !== 2'b00 || locked !== 1'b0 || lost !== 1'b0 || count_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop: got state=%b locked=%b lost=%b cv=%b expected 00/0/0/0",
                     state, locked, lost, count_valid);
        end
        checks++;
        if (edge_count !== 16'(m_edge) || in_range !== m_inr) begin
            errors++;
            $display("FAIL idle_hold: got %0d/%b expected %0d/%b", edge_count, in_range, m_edge, m_inr);
        end
        for (int i = 0; i < 4; i++) step(1'b0);
        run_window(256, 20, 1'b0, WIN);
    endtask

    task automatic test_reset_mid();
        lock_up();
        run_window(256, 16, 1'b0, 300);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({edge_count, count_valid, in_range, locked, lost, state} !== 22'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {edge_count, count_valid, in_range, locked, lost, state});
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        rstn   = 1'b1;
        prev_d = 1'b0;
        model_idle();
        m_edge = 0;
        m_inr  = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        run_window(250, 16, 1'b0, WIN);
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_clock_loss();
        test_hysteresis();
        test_bounds();
        test_random();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
